// File: rtl/audio_avg_filter.sv
// audio_avg_filter: single-channel moving-average filter between the CODEC read
// side and write side. Keeps the last N pre-scaled samples in a circular buffer
// with a running sum, and presents either the average or the raw sample on a
// one-deep registered valid/ready output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | output register consumed; ready to accept a new sample
// S_FULL  | output register holds an unconsumed result; input stalled
module audio_avg_filter #(
    parameter int DATA_W = 24,
    parameter int LOG2_N = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_bypass,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic signed [DATA_W-1:0] i_in_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic signed [DATA_W-1:0] o_out_data,
    output logic                     o_primed
);

    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = LOG2_N + 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_buf [N];
    logic        [LOG2_N-1:0]  r_wp;
    logic signed [DATA_W-1:0]  r_sum;
    logic        [CNT_W-1:0]   r_cnt;
    logic signed [DATA_W-1:0]  r_out_data;

    logic signed [DATA_W-1:0]  w_scaled;
    logic signed [DATA_W-1:0]  w_new_sum;
    logic                      w_accept;
    logic                      w_drain;

    // Samples are pre-divided so the sum of N stored values cannot overflow;
    // the arithmetic shift truncates toward minus infinity.
    assign w_scaled  = i_in_data >>> LOG2_N;
    assign w_new_sum = r_sum + w_scaled - r_buf[r_wp];
    assign w_accept  = (r_state == S_EMPTY) && i_in_valid;
    assign w_drain   = (r_state == S_FULL) && i_out_ready;

    assign o_out_valid = (r_state == S_FULL);
    assign o_in_ready  = (r_state == S_EMPTY);
    assign o_out_data  = r_out_data;
    assign o_primed    = (r_cnt == CNT_W'(N));

    // Handshake FSM plus window state; buffer and sum update even in bypass so
    // the average is already correct when bypass is released.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_EMPTY;
            r_wp       <= '0;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_sum       <= w_new_sum;
                        r_buf[r_wp] <= w_scaled;
                        r_wp        <= r_wp + 1'b1;
                        if (r_cnt != CNT_W'(N)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_out_data  <= i_bypass ? i_in_data : w_new_sum;
                        r_state     <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_drain) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

endmodule
